// File: rtl/acl_spi_responder_if.sv
// acl_spi_responder_if: four-wire SPI bus between the FPGA-side master and the accelerometer stand-in.
interface acl_spi_responder_if;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic CS;
  modport master (output SCLK, output MOSI, output CS, input MISO);
  modport slave (input SCLK, input MOSI, input CS, output MISO);
endinterface

// File: rtl/acl_spi_responder.sv
// acl_spi_responder: SPI mode-0 accelerometer register emulator (0x0A write, 0x0B read, auto-increment).
// Define ACL_STATUS_REG_EN to add the STATUS register (0x0B, bit0 = data_ready).
module acl_spi_responder #(
  parameter logic [7:0] DEVID = 8'hAD,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  acl_spi_responder_if.slave   spi,
  input  logic [11:0]          x_data,
  input  logic [11:0]          y_data,
  input  logic [11:0]          z_data,
  input  logic                 sample_valid,
  output logic [7:0]           power_ctl,
  output logic                 measure,
  output logic                 busy
);
  localparam int LAST = SYNC_STAGES - 1;
  typedef enum logic [2:0] {IDLE, INSTR, ADDR, DATA, IGNORE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_s, mosi_s, cs_s;
  logic armed;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit, in_frame, byte_done;
  logic [2:0] cnt;
  logic [6:0] sh;
  logic [7:0] rx_byte, addr, tx, reg_rd, status_reg;
  logic rd, load_pend;
  logic [11:0] snap_x, snap_y, snap_z;
  // CS synchroniser resets low so a CS held low across reset never looks like a fresh fall
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      sclk_s <= '0;
      mosi_s <= '0;
      cs_s <= '0;
      armed <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi.SCLK};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi.MOSI};
      cs_s <= {cs_s[SYNC_STAGES-2:0], spi.CS};
      armed <= armed | cs_s[LAST];
    end
  assign sclk_rise = sclk_s[LAST-1] & ~sclk_s[LAST];
  assign sclk_fall = ~sclk_s[LAST-1] & sclk_s[LAST];
  assign cs_fall = cs_s[LAST] & ~cs_s[LAST-1];
  assign cs_rise = ~cs_s[LAST] & cs_s[LAST-1];
  assign mosi_bit = mosi_s[LAST-1];
  assign in_frame = state != IDLE;
  assign byte_done = sclk_rise & (cnt == 3'd7) & in_frame & ~cs_rise;
  assign rx_byte = {sh, mosi_bit};
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = cs_rise ? IDLE
      : (state == IDLE) ? (cs_fall ? INSTR : IDLE)
      : !byte_done ? state
      : (state == INSTR) ? ((rx_byte == 8'h0A || rx_byte == 8'h0B) ? ADDR : IGNORE)
      : (state == ADDR) ? DATA
      : state;
  end
  always_comb begin
    spi.MISO = ((state == ADDR || state == DATA) && rd && busy) ? tx[7] : 1'b0;
    busy = armed & ~cs_s[LAST];
    measure = power_ctl[1:0] == 2'b10;
  end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      snap_x <= '0;
      snap_y <= '0;
      snap_z <= '0;
      cnt <= '0;
      sh <= '0;
      tx <= '0;
      addr <= '0;
      rd <= 1'b0;
      load_pend <= 1'b0;
      power_ctl <= '0;
    end else if (cs_fall) begin
      snap_x <= x_data;
      snap_y <= y_data;
      snap_z <= z_data;
      cnt <= '0;
      tx <= '0;
      load_pend <= 1'b0;
    end else begin
      if (sclk_rise && in_frame) begin
        cnt <= cnt + 3'd1;
        sh <= {sh[5:0], mosi_bit};
      end
      if (byte_done && state == INSTR) rd <= rx_byte[0];
      if (byte_done && state == ADDR) begin
        addr <= rx_byte;
        load_pend <= rd;
      end
      if (byte_done && state == DATA) begin
        addr <= addr + 8'd1;
        load_pend <= rd;
        if (!rd && addr == 8'h2D) power_ctl <= rx_byte;
      end
      // the fall after a completed byte loads the next register, all other falls shift
      if (sclk_fall && rd && state == DATA) begin
        tx <= load_pend ? reg_rd : {tx[6:0], 1'b0};
        load_pend <= 1'b0;
      end
    end
`ifdef ACL_STATUS_REG_EN
  logic data_ready;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) data_ready <= 1'b0;
    else if (sample_valid) data_ready <= 1'b1;
    else if (byte_done && state == DATA && rd && addr == 8'h11) data_ready <= 1'b0;
  assign status_reg = {7'd0, data_ready};
`else
  logic unused_sample_valid;
  assign unused_sample_valid = sample_valid;
  assign status_reg = 8'h00;
`endif
  always_comb begin
    case (addr)
      8'h00: reg_rd = DEVID;
      8'h0B: reg_rd = status_reg;
      8'h0C: reg_rd = snap_x[7:0];
      8'h0D: reg_rd = {{4{snap_x[11]}}, snap_x[11:8]};
      8'h0E: reg_rd = snap_y[7:0];
      8'h0F: reg_rd = {{4{snap_y[11]}}, snap_y[11:8]};
      8'h10: reg_rd = snap_z[7:0];
      8'h11: reg_rd = {{4{snap_z[11]}}, snap_z[11:8]};
      8'h2D: reg_rd = power_ctl;
      default: reg_rd = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_acl_spi_responder.sv
// tb_acl_spi_responder: randomized frames against a register-map model of the accelerometer.
module tb_acl_spi_responder;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;
  acl_spi_responder_if spi();
  logic [11:0] x_data = '0, y_data = '0, z_data = '0;
  logic sample_valid = 1'b0;
  logic [7:0] power_ctl;
  logic measure, busy;
  int checks = 0, failures = 0;
  logic [7:0] m_pc = 8'h00;
  logic m_dr = 1'b0;
  logic [11:0] m_x, m_y, m_z;
  logic [7:0] fq[$];

  acl_spi_responder dut (
    .Clock(Clock), .Reset(Reset), .spi(spi),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .sample_valid(sample_valid), .power_ctl(power_ctl),
    .measure(measure), .busy(busy)
  );

  function automatic logic [7:0] m_reg(input logic [7:0] a);
    int sx = int'($signed(m_x)), sy = int'($signed(m_y)), sz = int'($signed(m_z));
    case (a)
      8'h00: return 8'hAD;
`ifdef ACL_STATUS_REG_EN
      8'h0B: return {7'd0, m_dr};
`endif
      8'h0C: return 8'(sx % 256);
      8'h0D: return 8'(sx >>> 8);
      8'h0E: return 8'(sy % 256);
      8'h0F: return 8'(sy >>> 8);
      8'h10: return 8'(sz % 256);
      8'h11: return 8'(sz >>> 8);
      8'h2D: return m_pc;
      default: return 8'h00;
    endcase
  endfunction

  task automatic clk_n(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi.MOSI = b;
    spi.SCLK = 1'b0;
    clk_n(5);
    r = spi.MISO;
    spi.SCLK = 1'b1;
    clk_n(5);
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], r[i]);
  endtask

  task automatic cs_low();
    spi.SCLK = 1'b0;
    spi.CS = 1'b0;
    m_x = x_data;
    m_y = y_data;
    m_z = z_data;
    clk_n(5);
  endtask

  task automatic cs_high();
    spi.SCLK = 1'b0;
    clk_n(5);
    spi.CS = 1'b1;
    clk_n(6);
  endtask

  task automatic check_regs(input string name);
    checks++;
    if (power_ctl !== m_pc || measure !== (m_pc[1:0] == 2'b10)) begin
      failures++;
      $display("FAIL %s regs: power_ctl=%02h measure=%b expected %02h %b", name, power_ctl, measure, m_pc, m_pc[1:0] == 2'b10);
    end
  endtask

  task automatic run_frame(input logic [7:0] q[$], input bit scramble, input string name);
    logic [7:0] r, exp, a;
    bit rd_f, wr_f;
    a = 8'h00;
    rd_f = 0;
    wr_f = 0;
    cs_low();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy: got %b expected 1", name, busy);
    end
    foreach (q[i]) begin
      if (i == 0) begin
        rd_f = q[0] == 8'h0B;
        wr_f = q[0] == 8'h0A;
      end
      exp = (i >= 2 && rd_f) ? m_reg(a) : 8'h00;
      spi_byte(q[i], r);
      checks++;
      if (r !== exp) begin
        failures++;
        $display("FAIL %s byte%0d: MISO got %02h expected %02h", name, i, r, exp);
      end
      if (i == 1) a = q[1];
      if (i >= 2) begin
        if (wr_f && a == 8'h2D) m_pc = q[i];
        if (rd_f && a == 8'h11) m_dr = 1'b0;
        a = a + 8'd1;
      end
      if (scramble && i == 1) begin
        x_data = 12'($urandom);
        y_data = 12'($urandom);
        z_data = 12'($urandom);
      end
    end
    cs_high();
    check_regs(name);
  endtask

  task automatic pulse_valid();
    sample_valid = 1'b1;
    clk_n(1);
    sample_valid = 1'b0;
    m_dr = 1'b1;
    clk_n(1);
  endtask

  task automatic test_reset();
    clk_n(3);
    checks++;
    if (spi.MISO !== 1'b0 || power_ctl !== 8'h00 || measure !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: MISO=%b power_ctl=%02h measure=%b busy=%b expected 0 00 0 0", spi.MISO, power_ctl, measure, busy);
    end
    Reset = 1'b1;
    clk_n(5);
  endtask

  task automatic test_devid();
    fq = {8'h0B, 8'h00, 8'h00};
    run_frame(fq, 0, "devid");
  endtask

  task automatic test_samples();
    x_data = 12'h123;
    y_data = 12'hF80;
    z_data = 12'h7FF;
    fq = {8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fq, 1, "samples");
  endtask

  task automatic test_write();
    fq = {8'h0A, 8'h2D, 8'h02};
    run_frame(fq, 0, "write");
    checks++;
    if (power_ctl !== 8'h02 || measure !== 1'b1) begin
      failures++;
      $display("FAIL write_abs: power_ctl=%02h measure=%b expected 02 1", power_ctl, measure);
    end
    fq = {8'h0B, 8'h2D, 8'h00};
    run_frame(fq, 0, "readback");
  endtask

  task automatic test_ignore();
    fq = {8'h55, 8'h0A, 8'h2D, 8'hFF};
    run_frame(fq, 0, "ignore");
    fq = {8'h0B, 8'h2D, 8'h00};
    run_frame(fq, 0, "after_ignore");
  endtask

  task automatic test_wrap();
    fq = {8'h0B, 8'hFF, 8'h00, 8'h00};
    run_frame(fq, 0, "wrap");
  endtask

  task automatic test_partial();
    logic [7:0] r;
    logic b;
    cs_low();
    spi_byte(8'h0A, r);
    spi_byte(8'h2D, r);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    cs_high();
    check_regs("partial");
    cs_low();
    cs_high();
    check_regs("empty_frame");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r;
    logic b;
    fq = {8'h0A, 8'h2D, 8'h03};
    run_frame(fq, 0, "pre_reset");
    cs_low();
    spi_byte(8'h0A, r);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
    Reset = 1'b0;
    m_pc = 8'h00;
    m_dr = 1'b0;
    clk_n(2);
    checks++;
    if (spi.MISO !== 1'b0 || power_ctl !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: MISO=%b power_ctl=%02h busy=%b expected 0 00 0", spi.MISO, power_ctl, busy);
    end
    Reset = 1'b1;
    clk_n(5);
    spi_byte(8'h0A, r);
    spi_byte(8'h2D, r);
    spi_byte(8'h02, r);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL no_fresh_fall busy: got %b expected 0", busy);
    end
    cs_high();
    check_regs("no_fresh_fall");
    fq = {8'h0B, 8'h00, 8'h00};
    run_frame(fq, 0, "post_reset");
  endtask

  task automatic test_status();
    pulse_valid();
    fq = {8'h0B, 8'h0B, 8'h00};
    run_frame(fq, 0, "status_set");
    fq = {8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fq, 0, "status_burst");
    fq = {8'h0B, 8'h0B, 8'h00};
    run_frame(fq, 0, "status_clear");
  endtask

  task automatic test_random();
    logic [7:0] addrs[12];
    addrs = '{8'h00, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h2D, 8'h2C, 8'hFE, 8'hFF};
    for (int f = 0; f < 40; f++) begin
      x_data = 12'($urandom);
      y_data = 12'($urandom);
      z_data = 12'($urandom);
      if ($urandom_range(0, 1) == 1) pulse_valid();
      fq.delete();
      case ($urandom_range(0, 4))
        0, 1: fq.push_back(8'h0A);
        2, 3: fq.push_back(8'h0B);
        default: fq.push_back(8'($urandom));
      endcase
      fq.push_back($urandom_range(0, 3) == 0 ? 8'($urandom) : addrs[$urandom_range(0, 11)]);
      for (int k = $urandom_range(0, 4); k > 0; k--) fq.push_back(8'($urandom));
      run_frame(fq, $urandom_range(0, 1) == 1, "random");
    end
  endtask

  initial begin
    spi.CS = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    test_reset();
    test_devid();
    test_samples();
    test_write();
    test_ignore();
    test_wrap();
    test_partial();
    test_reset_midframe();
    test_status();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
